// File: rtl/timer_sched.sv
// Shared 8-bit timer, APB-programmed, round-robin allocated to four requesters.
// Latency: LOAD -> EXPIRE is (reload+1)*(PRESC+1)+1 cycles; APB reads are combinational.
// Backpressure: none, PREADY is tied high; requests queue as pending bits until granted.
module timer_sched (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [2:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic       trig,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_EXPIRE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] load_r [4];
    logic       en;
    logic [3:0] mask;
    logic [7:0] presc;
    logic [7:0] count;
    logic [7:0] presc_cnt;
    logic [3:0] pending;
    logic [1:0] rr_ptr;
    logic [1:0] ch;

    logic       wr;
    logic       abort;
    logic       tick;
    logic [3:0] eligible;
    logic [3:0] ch_onehot;
    logic [1:0] sel;
    logic       found;
    logic [1:0] idx;

    assign wr        = PSEL & PENABLE & PWRITE;
    // Clearing EN while the timer is loading or counting drops the allocation at once.
    assign abort     = wr && (PADDR == 3'd4) && !PWDATA[0] &&
                       ((state == S_LOAD) || (state == S_COUNT));
    assign tick      = (presc_cnt == presc);
    assign eligible  = pending & mask;
    assign ch_onehot = 4'b0001 << ch;
    assign PREADY    = 1'b1;

    // Round-robin pick: first eligible channel at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && eligible[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state decode; abort wins over a simultaneous expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (en && found) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = abort ? S_IDLE : S_COUNT;
            S_COUNT: begin
                if (abort)                      state_nxt = S_IDLE;
                else if (tick && count == 8'd0) state_nxt = S_EXPIRE;
            end
            S_EXPIRE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state and the latched channel.
    always_comb begin
        busy  = (state != S_IDLE);
        grant = busy ? ch_onehot : 4'b0000;
        trig  = (state == S_EXPIRE);
        done  = trig ? ch_onehot : 4'b0000;
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Registers, pending set/clear, arbitration bookkeeping and the counter datapath.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < 4; i++) load_r[i] <= 8'd0;
            en        <= 1'b0;
            mask      <= 4'd0;
            presc     <= 8'd0;
            count     <= 8'd0;
            presc_cnt <= 8'd0;
            pending   <= 4'd0;
            rr_ptr    <= 2'd0;
            ch        <= 2'd0;
        end else begin
            if (wr) begin
                case (PADDR)
                    3'd0, 3'd1, 3'd2, 3'd3: load_r[PADDR[1:0]] <= PWDATA;
                    3'd4: begin
                        en   <= PWDATA[0];
                        mask <= PWDATA[7:4];
                    end
                    3'd7:    presc <= PWDATA;
                    default: ;
                endcase
            end

            // A new request in the clearing cycle keeps the bit set.
            if (state == S_LOAD && !abort) pending <= (pending & ~ch_onehot) | req;
            else                           pending <= pending | req;

            case (state)
                S_IDLE: begin
                    if (en && found) begin
                        ch     <= sel;
                        rr_ptr <= sel + 2'd1;
                    end
                end
                S_LOAD: begin
                    if (!abort) begin
                        count     <= load_r[ch];
                        presc_cnt <= 8'd0;
                    end
                end
                S_COUNT: begin
                    if (!abort) begin
                        if (tick) begin
                            presc_cnt <= 8'd0;
                            if (count != 8'd0) count <= count - 8'd1;
                        end else begin
                            presc_cnt <= presc_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational APB read mux.
    always_comb begin
        PRDATA = 8'd0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                3'd0, 3'd1, 3'd2, 3'd3: PRDATA = load_r[PADDR[1:0]];
                3'd4:    PRDATA = {mask, 3'b000, en};
                3'd5:    PRDATA = {1'b0, ch, busy, pending};
                3'd6:    PRDATA = count;
                default: PRDATA = presc;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a cycle-arithmetic reference model.
// Expiry is predicted in closed form: (V+1)*(P+1)+1 cycles after LOAD.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_timer_sched;

    logic       PCLK;
    logic       PRESETn;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] done;
    logic       trig;
    logic       busy;

    timer_sched dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .req(req), .grant(grant), .done(done),
        .trig(trig), .busy(busy)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one timer allocation described by its LOAD and EXPIRE cycle numbers.
    int         cyc = 0;
    int         m_start = 0;
    int         m_end = 0;
    int         m_v = 0;
    int         m_p = 0;
    int         m_hold = 0;
    int         m_pick;
    int         m_sc;
    logic [7:0] m_load [4];
    logic       m_en = 1'b0;
    logic [3:0] m_mask = 4'd0;
    logic [3:0] m_pending = 4'd0;
    logic [7:0] m_presc = 8'd0;
    logic [1:0] m_rr = 2'd0;
    logic [1:0] m_ch = 2'd0;
    logic       m_active = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_wr, m_in_load, m_in_count, m_in_exp, m_abort;
    logic [3:0] m_elig;

    function automatic int shown_count();
        if (!m_active || cyc == m_start) return m_hold;
        if (cyc >= m_end) return 0;
        return m_v - (cyc - m_start - 1) / (m_p + 1);
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd4:    return {m_mask, 3'b000, m_en};
            3'd5:    return {1'b0, m_ch, m_active, m_pending};
            3'd6:    return 8'(shown_count());
            3'd7:    return m_presc;
            default: return m_load[a[1:0]];
        endcase
    endfunction

    // Advance the model by one clock using the inputs as seen at this edge.
    always @(posedge PCLK) begin : model_step
        if (!PRESETn) begin
            for (int i = 0; i < 4; i++) m_load[i] = 8'd0;
            m_en = 1'b0; m_mask = 4'd0; m_presc = 8'd0; m_pending = 4'd0;
            m_rr = 2'd0; m_ch = 2'd0; m_active = 1'b0; m_hold = 0;
            m_valid = 1'b1;
        end else begin
            m_wr       = PSEL && PENABLE && PWRITE;
            m_in_load  = m_active && cyc == m_start;
            m_in_count = m_active && cyc > m_start && cyc < m_end;
            m_in_exp   = m_active && cyc == m_end;
            m_abort    = m_wr && PADDR == 3'd4 && !PWDATA[0] && (m_in_load || m_in_count);
            m_sc       = shown_count();
            m_elig     = m_pending & m_mask;
            if (m_abort) begin
                m_active = 1'b0;
                if (m_in_count) m_hold = m_sc;
            end else if (m_in_load) begin
                m_v   = int'(m_load[m_ch]);
                m_p   = int'(m_presc);
                m_end = m_start + (m_v + 1) * (m_p + 1) + 1;
            end else if (m_in_exp) begin
                m_active = 1'b0;
                m_hold   = 0;
            end else if (!m_active && m_en && m_elig != 4'd0) begin
                m_pick = -1;
                for (int k = 0; k < 4; k++)
                    if (m_pick < 0 && m_elig[(int'(m_rr) + k) % 4]) m_pick = (int'(m_rr) + k) % 4;
                m_ch     = 2'(m_pick);
                m_rr     = 2'(m_pick + 1);
                m_active = 1'b1;
                m_start  = cyc + 1;
                m_end    = cyc + 1000000;
            end
            if (m_in_load && !m_abort) m_pending = m_pending & ~(4'b0001 << m_ch);
            m_pending = m_pending | req;
            if (m_wr) begin
                case (PADDR)
                    3'd4: begin m_en = PWDATA[0]; m_mask = PWDATA[7:4]; end
                    3'd5, 3'd6: ;
                    3'd7: m_presc = PWDATA;
                    default: m_load[PADDR[1:0]] = PWDATA;
                endcase
            end
        end
        cyc++;
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge PCLK) begin
        if (m_valid) begin
            check("busy", 32'(busy), 32'(m_active));
            check("grant", 32'(grant), m_active ? 32'(4'b0001 << m_ch) : 32'd0);
            check("trig", 32'(trig), 32'(m_active && cyc == m_end));
            check("done", 32'(done), (m_active && cyc == m_end) ? 32'(4'b0001 << m_ch) : 32'd0);
            check("pready", 32'(PREADY), 32'd1);
            check("prdata", 32'(PRDATA), (PSEL && !PWRITE) ? 32'(model_read(PADDR)) : 32'd0);
        end
    end

    // Event recorder for the directed literal checks.
    int         ncyc = 0;
    int         load_cyc = 0;
    int         trig_cyc = 0;
    int         trig_cnt = 0;
    logic [3:0] first_grant = 4'd0;
    logic [3:0] last_done = 4'd0;
    logic [3:0] prev_grant = 4'd0;
    logic [3:0] done_q[$];
    always @(negedge PCLK) begin
        ncyc++;
        if (m_valid) begin
            if (grant != 4'd0 && prev_grant == 4'd0) begin
                load_cyc    = ncyc;
                first_grant = grant;
            end
            if (trig) begin
                trig_cyc  = ncyc;
                trig_cnt++;
                last_done = done;
                done_q.push_back(done);
            end
            prev_grant = grant;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_wr(input logic [2:0] a, input logic [7:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        wait_cycles(1);
        PENABLE = 1'b1;
        wait_cycles(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [2:0] a, output logic [7:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        #3;
        d = PRDATA;
        wait_cycles(1);
        PSEL = 1'b0;
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v;
        wait_cycles(1);
        req = 4'd0;
    endtask

    task automatic do_reset(input int n);
        PRESETn = 1'b0;
        wait_cycles(n);
        PRESETn = 1'b1;
    endtask

    logic [7:0] rd;
    logic [7:0] cnt_q[$];
    int         t0;

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 3'd0; PWDATA = 8'd0; req = 4'd0;

        // Reset values of the outputs.
        do_reset(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done_trig", 32'({done, trig}), 32'd0);
        check("rst_pready", 32'(PREADY), 32'd1);

        // Channel 0, reload 2, no prescale: expiry 4 cycles after LOAD.
        apb_wr(3'd0, 8'd2); apb_wr(3'd7, 8'd0); apb_wr(3'd4, 8'h11);
        t0 = trig_cnt;
        pulse_req(4'b0001);
        for (int i = 0; i < 40 && trig_cnt == t0; i++) wait_cycles(1);
        wait_cycles(2);
        check("t1_trig_once", 32'(trig_cnt - t0), 32'd1);
        check("t1_grant", 32'(first_grant), 32'h1);
        check("t1_latency", 32'(trig_cyc - load_cyc), 32'd4);
        check("t1_done", 32'(last_done), 32'h1);
        apb_rd(3'd5, rd);
        check("t1_status", 32'(rd), 32'h00);

        // Channel 1, PRESC=3, reload 1: COUNT shows 1 then 0; expiry (1+1)*(3+1)+1 = 9 after LOAD.
        apb_wr(3'd7, 8'd3); apb_wr(3'd1, 8'd1); apb_wr(3'd4, 8'h21);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 3'd6;
        cnt_q.delete();
        t0 = trig_cnt;
        pulse_req(4'b0010);
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK); #1;
            if (trig) break;
            if (busy && ncyc != load_cyc)
                if (cnt_q.size() == 0 || cnt_q[$] != PRDATA) cnt_q.push_back(PRDATA);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        check("t2_trig", 32'(trig_cnt - t0), 32'd1);
        check("t2_latency", 32'(trig_cyc - load_cyc), 32'd9);
        check("t2_done", 32'(last_done), 32'h2);
        check("t2_count_len", 32'(cnt_q.size()), 32'd2);
        if (cnt_q.size() == 2) begin
            check("t2_count_first", 32'(cnt_q[0]), 32'd1);
            check("t2_count_second", 32'(cnt_q[1]), 32'd0);
        end

        // All four channels at once from a fresh reset: served 0,1,2,3.
        do_reset(2);
        apb_wr(3'd4, 8'hF1);
        done_q.delete();
        t0 = trig_cnt;
        pulse_req(4'b1111);
        for (int i = 0; i < 100 && trig_cnt - t0 < 4; i++) wait_cycles(1);
        wait_cycles(3);
        check("t3_expiries", 32'(done_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < done_q.size()) check("t3_order", 32'(done_q[i]), 32'(4'b0001 << i));
        check("t3_idle", 32'(busy), 32'd0);
        apb_rd(3'd5, rd);
        check("t3_status", 32'(rd), 32'h60);

        // Abort mid-COUNT by clearing EN; re-enabling without a request stays idle.
        apb_wr(3'd0, 8'd10); apb_wr(3'd4, 8'h31);
        pulse_req(4'b0001);
        for (int i = 0; i < 10 && !busy; i++) wait_cycles(1);
        check("t4_granted", 32'(grant), 32'h1);
        wait_cycles(3);
        t0 = trig_cnt;
        apb_wr(3'd4, 8'h30);
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_grant", 32'(grant), 32'd0);
        apb_wr(3'd4, 8'h31);
        wait_cycles(5);
        check("t4_stay_idle", 32'(busy), 32'd0);
        check("t4_no_trig", 32'(trig_cnt - t0), 32'd0);

        // Masked channel stays pending until its mask bit is set.
        apb_wr(3'd4, 8'h21);
        pulse_req(4'b0001);
        wait_cycles(3);
        check("t5_no_grant", 32'(grant), 32'd0);
        apb_rd(3'd5, rd);
        check("t5_status", 32'(rd), 32'h01);
        apb_wr(3'd4, 8'h11);
        for (int i = 0; i < 10 && grant == 4'd0; i++) wait_cycles(1);
        check("t5_grant", 32'(grant), 32'h1);

        // Reset during COUNT: immediate idle, no expiry, every register reads 0.
        wait_cycles(3);
        check("t6_counting", 32'(busy), 32'd1);
        t0 = trig_cnt;
        do_reset(1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_grant", 32'(grant), 32'd0);
        for (int a = 0; a < 8; a++) begin
            apb_rd(3'(a), rd);
            check("t6_reg_zero", 32'(rd), 32'd0);
        end
        check("t6_no_trig", 32'(trig_cnt - t0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
